// File: rtl/pipelined_adder_if.sv
// Handshake and data bundle for pipelined_adder; the overflow wire exists only with PIPE_ADDER_OVF_EN.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef PIPE_ADDER_OVF_EN
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );
    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
`else
    modport master (
        output in_valid, a, b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );
    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: {carry_out, sum} = a + b + carry_in in STAGES slices; signed overflow with PIPE_ADDER_OVF_EN.
// Latency STAGES cycles, one result per cycle, bubbles advance like data.
// Backpressure: one enable (!out_valid || out_ready) freezes every stage; in_ready is that enable.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    // Element k is the register at the output of stage k.
    logic             vld_q  [STAGES];
    logic             cout_q [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] sum_q  [STAGES];
    logic             en;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf_q;
`endif

    assign en           = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_s;
        logic             cin_s;
        logic [WIDTH-1:0] a_s;
        logic [WIDTH-1:0] b_s;
        logic [WIDTH-1:0] sum_s;
        logic [WIDTH-1:0] sum_n;
        logic [SLICE-1:0] s_slice;
        logic [SLICE:0]   c;

        if (k == 0) begin : g_head
            assign vld_s = bus.in_valid;
            assign cin_s = bus.carry_in;
            assign a_s   = bus.a;
            assign b_s   = bus.b;
            assign sum_s = '0;
        end else begin : g_body
            assign vld_s = vld_q[k-1];
            assign cin_s = cout_q[k-1];
            assign a_s   = a_q[k-1];
            assign b_s   = b_q[k-1];
            assign sum_s = sum_q[k-1];
        end

        assign c[0] = cin_s;
        for (genvar i = 0; i < SLICE; i++) begin : g_fa
            localparam int J = k * SLICE + i;
            assign s_slice[i] = a_s[J] ^ b_s[J] ^ c[i];
            assign c[i+1]     = (a_s[J] & b_s[J]) | (c[i] & (a_s[J] ^ b_s[J]));
        end

        // Lower finished slices ride along; this stage drops its own slice in.
        always_comb begin
            sum_n                   = sum_s;
            sum_n[k*SLICE +: SLICE] = s_slice;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q[k]  <= 1'b0;
                cout_q[k] <= 1'b0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                sum_q[k]  <= '0;
            end else if (en) begin
                vld_q[k]  <= vld_s;
                cout_q[k] <= c[SLICE];
                a_q[k]    <= a_s;
                b_q[k]    <= b_s;
                sum_q[k]  <= sum_n;
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            // c[SLICE-1] is the carry into the MSB of the whole word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= c[SLICE-1] ^ c[SLICE];
                end
            end
        end
`endif
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.carry_out = cout_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
    assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (32/4 and 8/8 builds); overflow checks compile with PIPE_ADDER_OVF_EN.
module tb_pipelined_adder;
    localparam int W  = 32;
    localparam int S  = 4;
    localparam int W8 = 8;
    localparam int S8 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    pipelined_adder_if #(.WIDTH(W))  bus  ();
    pipelined_adder_if #(.WIDTH(W8)) bus8 ();

    pipelined_adder #(.WIDTH(W),  .STAGES(S))  dut  (.clk(clk), .rst(rst), .bus(bus));
    pipelined_adder #(.WIDTH(W8), .STAGES(S8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    // Expected results as {overflow, carry_out, sum}, in input order.
    logic [W+1:0]  exp_q  [$];
    logic [W8+1:0] exp8_q [$];

    function automatic logic [W+1:0] model32(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] t;
        logic       ovf;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        ovf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {ovf, t};
    endfunction

    function automatic logic [W8+1:0] model8(input logic [W8-1:0] x, input logic [W8-1:0] y, input logic ci);
        logic [W8:0] t;
        logic        ovf;
        t   = {1'b0, x} + {1'b0, y} + {{W8{1'b0}}, ci};
        ovf = (x[W8-1] == y[W8-1]) && (t[W8-1] != x[W8-1]);
        return {ovf, t};
    endfunction

    logic          s_in_x, s_out_x, s_ovld, s_irdy, s_cout, s_ovf;
    logic [W-1:0]  s_sum;
    logic          s8_out_x, s8_cout, s8_ovf;
    logic [W8-1:0] s8_sum;

    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic ordy);
        bus.in_valid = iv; bus.a = ia; bus.b = ib; bus.carry_in = ic; bus.out_ready = ordy;
        #1;
        s_irdy  = bus.in_ready;
        s_ovld  = bus.out_valid;
        s_in_x  = iv && bus.in_ready;
        s_out_x = bus.out_valid && ordy;
        s_sum   = bus.sum;
        s_cout  = bus.carry_out;
`ifdef PIPE_ADDER_OVF_EN
        s_ovf   = bus.overflow;
`else
        s_ovf   = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic iv, input logic [W8-1:0] ia, input logic [W8-1:0] ib,
                         input logic ic, input logic ordy, output logic in_x);
        bus8.in_valid = iv; bus8.a = ia; bus8.b = ib; bus8.carry_in = ic; bus8.out_ready = ordy;
        #1;
        in_x     = iv && bus8.in_ready;
        s8_out_x = bus8.out_valid && ordy;
        s8_sum   = bus8.sum;
        s8_cout  = bus8.carry_out;
`ifdef PIPE_ADDER_OVF_EN
        s8_ovf   = bus8.overflow;
`else
        s8_ovf   = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction; reports cycles from input transfer to output transfer.
    task automatic run_single(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                              output int lat, output logic [W-1:0] rs, output logic rc, output logic ro);
        lat = 0; rs = '0; rc = 1'b0; ro = 1'b0;
        step(1'b1, ia, ib, ic, 1'b1);
        for (int n = 1; n <= 20; n++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (s_out_x) begin
                lat = n; rs = s_sum; rc = s_cout; ro = s_ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.carry_in = 1'b0; bus8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.carry_out !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: out_valid=%b sum=%h carry_out=%b in_ready=%b, want 0 0 0 1",
                     bus.out_valid, bus.sum, bus.carry_out, bus.in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_prefill: out_valid=%b, want 1", bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: out_valid=%b, want 0", bus.out_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            if (s_ovld) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL reset_stale: %0d stale results, want 0", seen);
        end
    endtask

    task automatic test_latency();
        int lat; logic [W-1:0] rs; logic rc, ro;
        run_single(32'h0000_0005, 32'h0000_0003, 1'b1, lat, rs, rc, ro);
        tests_run++;
        if (lat != S || rs !== 32'h0000_0009 || rc !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency: lat=%0d sum=%h cout=%b, want %0d 00000009 0", lat, rs, rc, S);
        end
    endtask

    task automatic test_carry_chain();
        logic [W-1:0] ta [3]; logic [W-1:0] tb [3]; logic tc [3];
        logic [W-1:0] tsum [3]; logic tco [3];
        int lat; logic [W-1:0] rs; logic rc, ro;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0000; tc[0] = 1'b1; tsum[0] = 32'h0000_0000; tco[0] = 1'b1;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'h0000_0001; tc[1] = 1'b0; tsum[1] = 32'h0000_0000; tco[1] = 1'b1;
        ta[2] = 32'hFFFF_FFFF; tb[2] = 32'hFFFF_FFFF; tc[2] = 1'b1; tsum[2] = 32'hFFFF_FFFF; tco[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_single(ta[i], tb[i], tc[i], lat, rs, rc, ro);
            tests_run++;
            if (lat != S || rs !== tsum[i] || rc !== tco[i]) begin
                tests_failed++;
                $display("FAIL carry_chain[%0d]: lat=%0d sum=%h cout=%b, want %0d %h %b",
                         i, lat, rs, rc, S, tsum[i], tco[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent, got, first, last;
        logic [W-1:0] pa, pb; logic pc; logic [W+1:0] e;
        sent = 0; got = 0; first = -1; last = -1;
        exp_q.delete();
        for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
            pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
            step(sent < 100, pa, pb, pc, 1'b1);
            if (s_in_x) begin
                exp_q.push_back(model32(pa, pb, pc));
                sent++;
            end
            if (s_out_x) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_extra: unexpected result sum=%h", s_sum);
                end else begin
                    e = exp_q.pop_front();
                    if (s_sum !== e[W-1:0] || s_cout !== e[W]) begin
                        tests_failed++;
                        $display("FAIL b2b_data[%0d]: sum=%h cout=%b, want %h %b", got, s_sum, s_cout, e[W-1:0], e[W]);
                    end
                end
            end
        end
        tests_run++;
        if (got != 100 || sent != 100 || last - first + 1 != 100) begin
            tests_failed++;
            $display("FAIL b2b_count: sent=%0d got=%0d span=%0d, want 100 100 100", sent, got, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] pa, pb, prev_sum; logic pc, pv, ordy, prev_stall, prev_cout;
        logic [W+1:0] e; int sent, got, n;
        for (int phase = 0; phase < 2; phase++) begin
            n = (phase == 0) ? 30 : 60;
            sent = 0; got = 0; exp_q.delete();
            prev_stall = 1'b0; prev_sum = '0; prev_cout = 1'b0;
            pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
            for (int cyc = 0; cyc < 600 && got < n; cyc++) begin
                if (phase == 0) begin
                    ordy = !(cyc >= 8 && cyc < 14);
                    pv   = (sent < n);
                end else begin
                    ordy = 1'($urandom_range(0, 1));
                    pv   = (sent < n) && ($urandom_range(0, 9) < 7);
                end
                step(pv, pa, pb, pc, ordy);
                if (prev_stall) begin
                    tests_run++;
                    if (s_ovld !== 1'b1 || s_sum !== prev_sum || s_cout !== prev_cout) begin
                        tests_failed++;
                        $display("FAIL bp_stable: valid=%b sum=%h cout=%b, want 1 %h %b", s_ovld, s_sum, s_cout, prev_sum, prev_cout);
                    end
                end
                if (s_ovld && !ordy) begin
                    tests_run++;
                    if (s_irdy !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL bp_in_ready: in_ready=%b while stalled, want 0", s_irdy);
                    end
                end
                if (s_in_x) begin
                    exp_q.push_back(model32(pa, pb, pc));
                    sent++;
                    pa = $urandom; pb = $urandom; pc = 1'($urandom_range(0, 1));
                end
                if (s_out_x) begin
                    got++;
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL bp_extra: unexpected result sum=%h", s_sum);
                    end else begin
                        e = exp_q.pop_front();
                        if (s_sum !== e[W-1:0] || s_cout !== e[W]) begin
                            tests_failed++;
                            $display("FAIL bp_data[%0d]: sum=%h cout=%b, want %h %b", got, s_sum, s_cout, e[W-1:0], e[W]);
                        end
                    end
                end
                prev_stall = s_ovld && !ordy;
                prev_sum   = s_sum;
                prev_cout  = s_cout;
            end
            tests_run++;
            if (sent != n || got != n || exp_q.size() != 0) begin
                tests_failed++;
                $display("FAIL bp_count[%0d]: sent=%0d got=%0d left=%0d, want %0d %0d 0", phase, sent, got, exp_q.size(), n, n);
            end
        end
    endtask

`ifdef PIPE_ADDER_OVF_EN
    task automatic test_overflow();
        int lat; logic [W-1:0] rs; logic rc, ro;
        run_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, rs, rc, ro);
        tests_run++;
        if (lat != S || rs !== 32'h8000_0000 || rc !== 1'b0 || ro !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_pos: sum=%h cout=%b ovf=%b, want 80000000 0 1", rs, rc, ro);
        end
        run_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, rs, rc, ro);
        tests_run++;
        if (lat != S || rs !== 32'h0000_0000 || rc !== 1'b1 || ro !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_wrap: sum=%h cout=%b ovf=%b, want 00000000 1 0", rs, rc, ro);
        end
        run_single(32'h8000_0000, 32'h8000_0000, 1'b0, lat, rs, rc, ro);
        tests_run++;
        if (lat != S || rs !== 32'h0000_0000 || rc !== 1'b1 || ro !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_neg: sum=%h cout=%b ovf=%b, want 00000000 1 1", rs, rc, ro);
        end
    endtask
`endif

    task automatic test_slice1();
        logic [W8-1:0] pa, pb; logic pc, ordy, in_x; logic [W8+1:0] e;
        int sent, got, lat;
        bus.in_valid = 1'b0;
        // Single transaction through the 8-stage build to pin its latency.
        lat = 0;
        step8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, in_x);
        for (int n = 1; n <= 20; n++) begin
            step8(1'b0, '0, '0, 1'b0, 1'b1, in_x);
            if (s8_out_x) begin lat = n; break; end
        end
        tests_run++;
        if (lat != S8 || s8_sum !== 8'h00 || s8_cout !== 1'b1 || s8_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL s1_wrap: lat=%0d sum=%h cout=%b ovf=%b, want %0d 00 1 0", lat, s8_sum, s8_cout, s8_ovf, S8);
        end
        sent = 0; got = 0; exp8_q.delete();
        pa = 8'h7F; pb = 8'h01; pc = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
            ordy = 1'($urandom_range(0, 1));
            step8(sent < 40, pa, pb, pc, ordy, in_x);
            if (in_x) begin
                exp8_q.push_back(model8(pa, pb, pc));
                sent++;
                pa = 8'($urandom); pb = 8'($urandom); pc = 1'($urandom_range(0, 1));
            end
            if (s8_out_x) begin
                got++;
                tests_run++;
                if (exp8_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL s1_extra: unexpected result sum=%h", s8_sum);
                end else begin
                    e = exp8_q.pop_front();
`ifdef PIPE_ADDER_OVF_EN
                    if (s8_sum !== e[W8-1:0] || s8_cout !== e[W8] || s8_ovf !== e[W8+1]) begin
`else
                    if (s8_sum !== e[W8-1:0] || s8_cout !== e[W8]) begin
`endif
                        tests_failed++;
                        $display("FAIL s1_data[%0d]: sum=%h cout=%b ovf=%b, want %h %b %b",
                                 got, s8_sum, s8_cout, s8_ovf, e[W8-1:0], e[W8], e[W8+1]);
                    end
                end
            end
        end
        tests_run++;
        if (sent != 40 || got != 40) begin
            tests_failed++;
            $display("FAIL s1_count: sent=%0d got=%0d, want 40 40", sent, got);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_carry_chain();
        test_back_to_back();
        test_backpressure();
`ifdef PIPE_ADDER_OVF_EN
        test_overflow();
`endif
        test_slice1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
